// File: rtl/r4mdc_commutator_if.sv
// Lane bus for the R4MDC commutator: four complex input lanes with a valid
// strobe and mode select, four registered output lanes with valid and primed.
interface r4mdc_commutator_if #(
    parameter int WL = 16
);
    logic              in_valid;
    logic [2*WL-1:0]   in0, in1, in2, in3;
    logic              bypass;
    logic              out_valid;
    logic [2*WL-1:0]   out0, out1, out2, out3;
    logic              primed;

    modport master (
        output in_valid, in0, in1, in2, in3, bypass,
        input  out_valid, out0, out1, out2, out3, primed
    );

    modport slave (
        input  in_valid, in0, in1, in2, in3, bypass,
        output out_valid, out0, out1, out2, out3, primed
    );
endinterface

// File: rtl/r4mdc_commutator.sv
// Radix-4 multipath delay commutator: input delay bank (k*D), rotating 4:4
// switch driven by the segment phase, output delay bank ((3-j)*D), then a
// registered output stage. Bypass passes lanes straight through; any change
// of the bypass input performs a soft clear and drops that cycle's beat.

// Enable-gated shift register of LEN (>=1) words, cleared by reset.
module r4mdc_dly #(
    parameter int W   = 32,
    parameter int LEN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);
    logic [LEN-1:0][W-1:0] sr_q;

    // Shift one position per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q[0] <= din_i;
            for (int i = 1; i < LEN; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign dout_o = sr_q[LEN-1];
endmodule

module r4mdc_commutator #(
    parameter int WL = 16,
    parameter int D  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    r4mdc_commutator_if.slave bus
);
    localparam int W  = 2 * WL;
    localparam int CW = $clog2(D) + 2;
    localparam logic [CW-1:0] PRIME_CNT = CW'(3 * D - 1);

    logic [3:0][W-1:0] in_w, a_w, b_w, c_w;
    logic [3:0][W-1:0] out_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              byp_q, primed_q, out_valid_q;
    logic              mode_chg, adv;
    logic [1:0]        phase;

    assign in_w     = {bus.in3, bus.in2, bus.in1, bus.in0};
    assign mode_chg = bus.bypass != byp_q;
    // Delays and counter move only on accepted beats in commutate mode.
    assign adv      = bus.in_valid & ~mode_chg & ~byp_q;
    assign phase    = cnt_q[CW-1:CW-2];
    assign cnt_d    = cnt_q + 1'b1;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            // Input bank: lane k delayed by k*D beats.
            if (k == 0) begin : g_in0
                assign a_w[k] = in_w[k];
            end else begin : g_indly
                r4mdc_dly #(.W(W), .LEN(k * D)) u_idly (
                    .clk(clk), .rst_n(rst_n), .en_i(adv),
                    .din_i(in_w[k]), .dout_o(a_w[k])
                );
            end
            // Output bank: lane j delayed by (3-j)*D beats.
            if (k == 3) begin : g_out3
                assign c_w[k] = b_w[k];
            end else begin : g_odly
                r4mdc_dly #(.W(W), .LEN((3 - k) * D)) u_odly (
                    .clk(clk), .rst_n(rst_n), .en_i(adv),
                    .din_i(b_w[k]), .dout_o(c_w[k])
                );
            end
        end
    endgenerate

    // Rotating switch: output j takes delayed lane (p - j) mod 4.
    always_comb begin
        b_w = '0;
        for (int j = 0; j < 4; j++) b_w[j] = a_w[2'(phase - 2'(j))];
    end

    // Mode register, beat counter, primed flag and registered outputs.
    // out_valid uses the registered primed flag, so the first valid output
    // carries beat 3D, the first beat whose switched data is fully refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q       <= 1'b0;
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (mode_chg) begin
            byp_q       <= bus.bypass;
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (byp_q) begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) out_q <= in_w;
        end else begin
            out_valid_q <= bus.in_valid & primed_q;
            if (bus.in_valid) begin
                cnt_q <= cnt_d;
                out_q <= c_w;
                if (cnt_q == PRIME_CNT) primed_q <= 1'b1;
            end
        end
    end

    assign bus.out0      = out_q[0];
    assign bus.out1      = out_q[1];
    assign bus.out2      = out_q[2];
    assign bus.out3      = out_q[3];
    assign bus.out_valid = out_valid_q;
    assign bus.primed    = primed_q;
endmodule
